// File: rtl/sniffer_pkg.sv
// rtl/sniffer_pkg.sv - shared types and defaults for the match buffer arbiter
package sniffer_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 10;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_DROP   = 2'd1,
        ST_FLUSH  = 2'd2
    } state_e;

    // Event counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/ring_ptr.sv
// rtl/ring_ptr.sv - wrapping ring-buffer pointer with clear and increment enable
module ring_ptr
    import sniffer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clr,
    input  logic              inc_en,
    output logic [ADDR_W-1:0] ptr
);

    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;

    // Clear wins over increment; the top address rolls over to zero naturally.
    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc_en) begin
            ptr_d = ptr_q + ADDR_W'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/match_buffer_arbiter.sv
// rtl/match_buffer_arbiter.sv - packet capture buffer sharing one single-port memory with a host reader
module match_buffer_arbiter
    import sniffer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              cap_req,
    input  logic [DATA_W-1:0] cap_data,
    input  logic              cap_eop,
    output logic              cap_gnt,
    input  logic              host_req,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              flush,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   used,
    output logic [31:0]       pkt_count,
    output logic [31:0]       drop_count
);

    localparam logic [ADDR_W:0] DEPTH    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] USED_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [ADDR_W:0]   used_q, used_d;
    logic              rr_cap_q, rr_cap_d;
    logic              in_pkt_q, in_pkt_d;
    logic              drop_arm_q, drop_arm_d;
    logic [31:0]       pkt_q, pkt_d;
    logic [31:0]       drop_q, drop_d;
    logic              rvalid_q;
    logic              wr_en;
    logic              cap_elig;
    logic              host_elig;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    assign full  = (used_q == DEPTH);
    assign empty = (used_q == '0);
    assign used  = used_q;

    assign cap_elig  = cap_req && !full;
    assign host_elig = host_req && !empty;

    ring_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
        .clk    (clk),
        .n_rst  (n_rst),
        .clr    (flush),
        .inc_en (wr_en),
        .ptr    (wr_ptr)
    );

    ring_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
        .clk    (clk),
        .n_rst  (n_rst),
        .clr    (flush),
        .inc_en (host_gnt),
        .ptr    (rd_ptr)
    );

    // Arbitration, packet-drop FSM and counter next-state.
    // drop_arm marks a DROP entered because the buffer overflowed; a DROP
    // entered only because a flush cut a packet short is not counted.
    always_comb begin
        state_d    = state_q;
        rr_cap_d   = rr_cap_q;
        in_pkt_d   = in_pkt_q;
        drop_arm_d = drop_arm_q;
        pkt_d      = pkt_q;
        drop_d     = drop_q;
        cap_gnt    = 1'b0;
        host_gnt   = 1'b0;
        wr_en      = 1'b0;

        if (flush) begin
            state_d = ST_FLUSH;
        end else begin
            case (state_q)
                ST_ACTIVE: begin
                    if (cap_req && full) begin
                        cap_gnt  = 1'b1;
                        host_gnt = host_elig;
                        if (cap_eop) begin
                            drop_d = sat_inc(drop_q);
                        end else begin
                            state_d    = ST_DROP;
                            drop_arm_d = 1'b1;
                        end
                    end else if (cap_elig && host_elig) begin
                        cap_gnt  = rr_cap_q;
                        host_gnt = !rr_cap_q;
                        wr_en    = rr_cap_q;
                        rr_cap_d = !rr_cap_q;
                    end else begin
                        cap_gnt  = cap_elig;
                        host_gnt = host_elig;
                        wr_en    = cap_elig;
                    end
                end
                ST_DROP: begin
                    cap_gnt  = cap_req;
                    host_gnt = host_elig;
                    if (cap_req && cap_eop) begin
                        if (drop_arm_q) begin
                            drop_d = sat_inc(drop_q);
                        end
                        drop_arm_d = 1'b0;
                        state_d    = ST_ACTIVE;
                    end
                end
                ST_FLUSH: begin
                    state_d = in_pkt_q ? ST_DROP : ST_ACTIVE;
                end
                default: begin
                    state_d = ST_ACTIVE;
                end
            endcase
        end

        if (cap_gnt) begin
            in_pkt_d = !cap_eop;
        end
        if (wr_en && cap_eop) begin
            pkt_d = sat_inc(pkt_q);
        end

        // Nothing may be granted while reset is asserted.
        if (!n_rst) begin
            cap_gnt  = 1'b0;
            host_gnt = 1'b0;
            wr_en    = 1'b0;
        end
    end

    // Occupancy: a write and a read never share a cycle.
    always_comb begin
        used_d = used_q;
        if (flush) begin
            used_d = '0;
        end else if (wr_en) begin
            used_d = used_q + USED_ONE;
        end else if (host_gnt) begin
            used_d = used_q - USED_ONE;
        end
    end

    // State, counters and read-valid pipeline register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= ST_ACTIVE;
            used_q     <= '0;
            rr_cap_q   <= 1'b1;
            in_pkt_q   <= 1'b0;
            drop_arm_q <= 1'b0;
            pkt_q      <= '0;
            drop_q     <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            used_q     <= used_d;
            rr_cap_q   <= rr_cap_d;
            in_pkt_q   <= in_pkt_d;
            drop_arm_q <= drop_arm_d;
            pkt_q      <= pkt_d;
            drop_q     <= drop_d;
            rvalid_q   <= host_gnt;
        end
    end

    assign mem_we      = wr_en;
    assign mem_addr    = wr_en ? wr_ptr : rd_ptr;
    assign mem_wdata   = cap_data;
    assign host_rvalid = rvalid_q;
    assign host_rdata  = rvalid_q ? mem_rdata : '0;
    assign pkt_count   = pkt_q;
    assign drop_count  = drop_q;

endmodule
